// File: rtl/sa_out_accum_if.sv
// Signal bundle between the systolic-array result side, the row-stream consumer
// and the output accumulator. The accumulator sits on the slave side.
interface sa_out_accum_if #(
    parameter int D_W  = 16,
    parameter int SA_R = 16,
    parameter int SA_C = 16
);
    localparam int RW = (SA_R > 1) ? $clog2(SA_R) : 1;

    logic                                 start;
    logic [3:0]                           tile_num;
    logic                                 sa_vld;
    logic [SA_R-1:0][SA_C-1:0][D_W-1:0]   sa_out;
    logic                                 sa_clr;
    logic                                 row_vld;
    logic                                 row_rdy;
    logic [SA_C-1:0][D_W-1:0]             row_data;
    logic [RW-1:0]                        row_idx;
    logic                                 row_last;
    logic                                 busy;
    logic                                 done;

    modport master (
        output start, tile_num, sa_vld, sa_out, row_rdy,
        input  sa_clr, row_vld, row_data, row_idx, row_last, busy, done
    );

    modport slave (
        input  start, tile_num, sa_vld, sa_out, row_rdy,
        output sa_clr, row_vld, row_data, row_idx, row_last, busy, done
    );
endinterface

// File: rtl/sa_out_accum.sv
// Accumulates K-split systolic-array result tiles with signed saturation and
// drains the finished matrix one row per beat over a valid/ready stream.
//
// state   | meaning
// S_IDLE  | waiting for start; accumulator holds the last result
// S_WAIT  | accumulating tiles, one per rising edge of sa_vld
// S_DRAIN | streaming accumulator rows 0..SA_R-1 downstream
module sa_out_accum #(
    parameter int D_W  = 16,
    parameter int SA_R = 16,
    parameter int SA_C = 16
) (
    input logic           clk,
    input logic           rst,
    sa_out_accum_if.slave bus
);
    localparam int RW = (SA_R > 1) ? $clog2(SA_R) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN} state_t;

    state_t                             state;
    logic [SA_R-1:0][SA_C-1:0][D_W-1:0] acc;
    logic                               vld_d;
    logic [3:0]                         tile_cnt;
    logic [3:0]                         tile_num;
    logic [RW-1:0]                      row;
    logic                               sa_clr;
    logic                               row_vld;
    logic                               busy;
    logic                               done;
    logic                               capture;

    // Overflow shows up as disagreement between the two top bits of the
    // sign-extended sum; clamp toward the sign of the true result.
    function automatic logic [D_W-1:0] sat_add(input logic [D_W-1:0] a,
                                               input logic [D_W-1:0] b);
        logic [D_W:0] s;
        s = {a[D_W-1], a} + {b[D_W-1], b};
        if (s[D_W] != s[D_W-1])
            return {s[D_W], {(D_W-1){~s[D_W]}}};
        return s[D_W-1:0];
    endfunction

    assign capture = bus.sa_vld & ~vld_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            acc      <= '0;
            vld_d    <= 1'b0;
            tile_cnt <= '0;
            tile_num <= '0;
            row      <= '0;
            sa_clr   <= 1'b0;
            row_vld  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            vld_d  <= bus.sa_vld;
            sa_clr <= 1'b0;
            done   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        acc      <= '0;
                        tile_cnt <= '0;
                        tile_num <= (bus.tile_num == 4'd0) ? 4'd1 : bus.tile_num;
                        busy     <= 1'b1;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (capture) begin
                        for (int r = 0; r < SA_R; r++)
                            for (int c = 0; c < SA_C; c++)
                                acc[r][c] <= sat_add(acc[r][c], bus.sa_out[r][c]);
                        tile_cnt <= tile_cnt + 4'd1;
                        sa_clr   <= 1'b1;
                        if (tile_cnt == tile_num - 4'd1) begin
                            row     <= '0;
                            row_vld <= 1'b1;
                            state   <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (bus.row_rdy) begin
                        if (row == RW'(SA_R - 1)) begin
                            row     <= '0;
                            row_vld <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state   <= S_IDLE;
                        end else begin
                            row <= row + RW'(1);
                        end
                    end
                end
                default: begin
                    row_vld <= 1'b0;
                    busy    <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.sa_clr   = sa_clr;
    assign bus.row_vld  = row_vld;
    assign bus.row_data = row_vld ? acc[row] : '0;
    assign bus.row_idx  = row;
    assign bus.row_last = row_vld && (row == RW'(SA_R - 1));
    assign bus.busy     = busy;
    assign bus.done     = done;
endmodule

// File: tb/tb_sa_out_accum.sv
// Directed bench for sa_out_accum: single tile, saturation, level hold,
// backpressure, ignored starts, zero tile count and mid-drain reset.
module tb_sa_out_accum;
    localparam int D_W  = 16;
    localparam int SA_R = 16;
    localparam int SA_C = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    logic [SA_C-1:0][D_W-1:0] rows_got [SA_R];
    int beats, order_bad, stall_bad, done_cnt, clr_cnt;

    sa_out_accum_if #(.D_W(D_W), .SA_R(SA_R), .SA_C(SA_C)) bus ();

    sa_out_accum #(.D_W(D_W), .SA_R(SA_R), .SA_C(SA_C)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [3:0] n);
        bus.tile_num = n;
        bus.start    = 1'b1;
        tick();
        bus.start    = 1'b0;
    endtask

    task automatic fill(input logic [D_W-1:0] v);
        for (int r = 0; r < SA_R; r++)
            for (int c = 0; c < SA_C; c++)
                bus.sa_out[r][c] = v;
    endtask

    // Raises sa_vld for one edge with the whole tile set to v; leaves it high.
    task automatic capture(input logic [D_W-1:0] v);
        fill(v);
        bus.sa_vld = 1'b1;
        tick();
    endtask

    // Runs the drain from the current sample point until done is seen.
    task automatic drain(input bit random_rdy);
        logic                     rdy;
        logic                     stalled;
        logic [SA_C-1:0][D_W-1:0] pdata;
        logic [3:0]               pidx;
        logic                     plast;
        beats = 0; order_bad = 0; stall_bad = 0; done_cnt = 0; clr_cnt = 0;
        stalled = 1'b0; pdata = '0; pidx = '0; plast = 1'b0;
        bus.sa_vld = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (bus.sa_clr) clr_cnt++;
            if (bus.done) begin
                done_cnt++;
                break;
            end
            rdy = random_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.row_rdy = rdy;
            if (bus.row_vld) begin
                if (stalled && (bus.row_idx !== pidx || bus.row_data !== pdata ||
                                bus.row_last !== plast))
                    stall_bad++;
                if (rdy) begin
                    if (bus.row_idx !== 4'(beats)) order_bad++;
                    if (bus.row_last !== (beats == SA_R - 1)) order_bad++;
                    if (beats < SA_R) rows_got[beats] = bus.row_data;
                    beats++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    pdata = bus.row_data; pidx = bus.row_idx; plast = bus.row_last;
                end
            end
            tick();
        end
        bus.row_rdy = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        total++;
        if ({bus.row_vld, bus.row_last, bus.sa_clr, bus.busy, bus.done} !== 5'b0 ||
            bus.row_data !== '0 || bus.row_idx !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got vld=%b last=%b clr=%b busy=%b done=%b idx=%0d, want all 0",
                     bus.row_vld, bus.row_last, bus.sa_clr, bus.busy, bus.done, bus.row_idx);
        end
    endtask

    task automatic test_single_tile();
        logic [SA_C-1:0][D_W-1:0] exp_row;
        pulse_start(4'd1);
        total++;
        if (bus.busy !== 1'b1) begin
            bad++; $display("FAIL single_busy: got %b want 1", bus.busy);
        end
        for (int r = 0; r < SA_R; r++)
            for (int c = 0; c < SA_C; c++)
                bus.sa_out[r][c] = 16'(r * 16 + c);
        bus.sa_vld = 1'b1;
        tick();
        total++;
        if (bus.sa_clr !== 1'b1 || bus.row_vld !== 1'b1 || bus.row_idx !== 4'd0) begin
            bad++;
            $display("FAIL single_first_beat: got clr=%b vld=%b idx=%0d want 1 1 0",
                     bus.sa_clr, bus.row_vld, bus.row_idx);
        end
        drain(1'b0);
        total++;
        if (beats !== 16 || order_bad !== 0 || done_cnt !== 1 || clr_cnt !== 1) begin
            bad++;
            $display("FAIL single_drain: got beats=%0d order_bad=%0d done=%0d clr=%0d want 16 0 1 1",
                     beats, order_bad, done_cnt, clr_cnt);
        end
        for (int r = 0; r < SA_R; r++) begin
            for (int c = 0; c < SA_C; c++) exp_row[c] = 16'(r * 16 + c);
            total++;
            if (rows_got[r] !== exp_row) begin
                bad++; $display("FAIL single_row%0d: got %h want %h", r, rows_got[r], exp_row);
            end
        end
        total++;
        if (bus.busy !== 1'b0) begin
            bad++; $display("FAIL single_idle_at_done: got busy=%b want 0", bus.busy);
        end
        tick();
        total++;
        if (bus.done !== 1'b0) begin
            bad++; $display("FAIL single_done_one_cycle: got %b want 0", bus.done);
        end
    endtask

    task automatic test_saturation();
        logic [D_W-1:0] va [5] = '{16'h7000, 16'h9000, 16'h2000, 16'h9000, 16'h7FFF};
        logic [D_W-1:0] vb [5] = '{16'h2000, 16'hF000, 16'hE000, 16'h9000, 16'h0001};
        logic [D_W-1:0] ve [5] = '{16'h7FFF, 16'h8000, 16'h0000, 16'h8000, 16'h7FFF};
        int             wrong;
        for (int k = 0; k < 5; k++) begin
            pulse_start(4'd2);
            capture(va[k]);
            total++;
            if (bus.sa_clr !== 1'b1 || bus.row_vld !== 1'b0) begin
                bad++;
                $display("FAIL sat%0d_first_capture: got clr=%b vld=%b want 1 0", k, bus.sa_clr, bus.row_vld);
            end
            bus.sa_vld = 1'b0;
            tick();
            capture(vb[k]);
            drain(1'b0);
            wrong = 0;
            for (int r = 0; r < SA_R; r++)
                for (int c = 0; c < SA_C; c++)
                    if (rows_got[r][c] !== ve[k]) wrong++;
            total++;
            if (wrong != 0 || beats != 16) begin
                bad++;
                $display("FAIL sat%0d_result: got row0[0]=%h beats=%0d wrong=%0d want %h 16 0",
                         k, rows_got[0][0], beats, wrong, ve[k]);
            end
        end
    endtask

    task automatic test_level_hold();
        int clr_seen = 0;
        int vld_seen = 0;
        int wrong = 0;
        pulse_start(4'd2);
        fill(16'h0100);
        bus.sa_vld = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.sa_clr) clr_seen++;
            if (bus.row_vld) vld_seen++;
        end
        total++;
        if (clr_seen != 1 || vld_seen != 0 || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL level_hold: got clr=%0d vld=%0d busy=%b want 1 0 1", clr_seen, vld_seen, bus.busy);
        end
        bus.sa_vld = 1'b0;
        tick();
        capture(16'h0200);
        total++;
        if (bus.sa_clr !== 1'b1 || bus.row_vld !== 1'b1) begin
            bad++;
            $display("FAIL level_second_capture: got clr=%b vld=%b want 1 1", bus.sa_clr, bus.row_vld);
        end
        drain(1'b0);
        for (int r = 0; r < SA_R; r++)
            for (int c = 0; c < SA_C; c++)
                if (rows_got[r][c] !== 16'h0300) wrong++;
        total++;
        if (wrong != 0) begin
            bad++; $display("FAIL level_result: got row0[0]=%h wrong=%0d want 0300", rows_got[0][0], wrong);
        end
    endtask

    task automatic test_backpressure();
        logic [SA_C-1:0][D_W-1:0] exp_row;
        int wrong = 0;
        pulse_start(4'd1);
        for (int r = 0; r < SA_R; r++)
            for (int c = 0; c < SA_C; c++)
                bus.sa_out[r][c] = 16'(16'hA000 + r * 256 + c);
        bus.sa_vld = 1'b1;
        tick();
        drain(1'b1);
        for (int r = 0; r < SA_R; r++) begin
            for (int c = 0; c < SA_C; c++) exp_row[c] = 16'(16'hA000 + r * 256 + c);
            if (rows_got[r] !== exp_row) wrong++;
        end
        total++;
        if (beats != 16 || order_bad != 0 || stall_bad != 0 || wrong != 0 || done_cnt != 1) begin
            bad++;
            $display("FAIL backpressure: got beats=%0d order=%0d stall=%0d rows_wrong=%0d done=%0d want 16 0 0 0 1",
                     beats, order_bad, stall_bad, wrong, done_cnt);
        end
    endtask

    task automatic test_start_ignored();
        int wrong = 0;
        pulse_start(4'd2);
        capture(16'h0010);
        bus.sa_vld = 1'b0;
        tick();
        pulse_start(4'd1);
        total++;
        if (bus.busy !== 1'b1 || bus.row_vld !== 1'b0) begin
            bad++; $display("FAIL start_in_wait: got busy=%b vld=%b want 1 0", bus.busy, bus.row_vld);
        end
        capture(16'h0020);
        bus.sa_vld = 1'b0;
        total++;
        if (bus.row_vld !== 1'b1) begin
            bad++; $display("FAIL start_in_wait_tilecnt: got vld=%b want 1", bus.row_vld);
        end
        pulse_start(4'd3);
        total++;
        if (bus.row_vld !== 1'b1 || bus.row_idx !== 4'd0 || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL start_in_drain: got vld=%b idx=%0d busy=%b want 1 0 1", bus.row_vld, bus.row_idx, bus.busy);
        end
        drain(1'b0);
        for (int r = 0; r < SA_R; r++)
            for (int c = 0; c < SA_C; c++)
                if (rows_got[r][c] !== 16'h0030) wrong++;
        total++;
        if (wrong != 0 || beats != 16) begin
            bad++; $display("FAIL start_ignored_result: got row0[0]=%h beats=%0d want 0030 16", rows_got[0][0], beats);
        end
        total++;
        if (bus.busy !== 1'b0) begin
            bad++; $display("FAIL start_ignored_idle: got busy=%b want 0", bus.busy);
        end
    endtask

    task automatic test_back_to_back();
        int wrong = 0;
        pulse_start(4'd0);
        capture(16'h0005);
        total++;
        if (bus.row_vld !== 1'b1) begin
            bad++; $display("FAIL zero_tiles_as_one: got vld=%b want 1", bus.row_vld);
        end
        drain(1'b0);
        for (int r = 0; r < SA_R; r++)
            for (int c = 0; c < SA_C; c++)
                if (rows_got[r][c] !== 16'h0005) wrong++;
        total++;
        if (wrong != 0) begin
            bad++; $display("FAIL zero_tiles_result: got row0[0]=%h want 0005", rows_got[0][0]);
        end
        pulse_start(4'd1);
        total++;
        if (bus.busy !== 1'b1) begin
            bad++; $display("FAIL start_on_done: got busy=%b want 1", bus.busy);
        end
        capture(16'h0007);
        drain(1'b0);
        total++;
        if (rows_got[15][15] !== 16'h0007 || done_cnt != 1) begin
            bad++; $display("FAIL back_to_back_result: got %h done=%0d want 0007 1", rows_got[15][15], done_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int done_seen = 0;
        int wrong = 0;
        pulse_start(4'd1);
        capture(16'h1234);
        bus.sa_vld  = 1'b0;
        bus.row_rdy = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        total++;
        if (bus.row_idx !== 4'd6) begin
            bad++; $display("FAIL reset_mid_progress: got idx=%0d want 6", bus.row_idx);
        end
        bus.row_rdy = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if ({bus.row_vld, bus.row_last, bus.sa_clr, bus.busy, bus.done} !== 5'b0 ||
            bus.row_data !== '0 || bus.row_idx !== '0) begin
            bad++;
            $display("FAIL reset_mid_outputs: got vld=%b last=%b clr=%b busy=%b done=%b idx=%0d want all 0",
                     bus.row_vld, bus.row_last, bus.sa_clr, bus.busy, bus.done, bus.row_idx);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.done) done_seen++;
        end
        total++;
        if (done_seen != 0) begin
            bad++; $display("FAIL reset_mid_no_done: got %0d done pulses want 0", done_seen);
        end
        pulse_start(4'd2);
        capture(16'h0001);
        bus.sa_vld = 1'b0;
        tick();
        capture(16'h0002);
        drain(1'b0);
        for (int r = 0; r < SA_R; r++)
            for (int c = 0; c < SA_C; c++)
                if (rows_got[r][c] !== 16'h0003) wrong++;
        total++;
        if (wrong != 0 || beats != 16) begin
            bad++; $display("FAIL reset_mid_fresh: got row0[0]=%h beats=%0d want 0003 16", rows_got[0][0], beats);
        end
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.tile_num = 4'd0;
        bus.sa_vld   = 1'b0;
        bus.sa_out   = '0;
        bus.row_rdy  = 1'b0;
        test_reset();
        test_single_tile();
        test_saturation();
        test_level_hold();
        test_backpressure();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sa_out_accum.md
# sa_out_accum

Downstream stage of the systolic-array wrapper. It captures the SA_R×SA_C result tile when the array's result-valid goes high and, across a programmable number of K-split tiles, accumulates the tiles with signed saturation. It then drains the finished matrix one row per beat over a valid/ready stream toward the softmax/buffer stage. After each capture it issues a one-cycle clear pulse so the array can be restarted for the next tile.

## Interface
Parameters:
- D_W, 16, element width; signed fixed point Q2.13 (1 sign, 2 int, 13 frac bits).
- SA_R, 16, tile rows, equal to the array's SA_R.
- SA_C, 16, tile columns, equal to the array's SA_C.

Ports:
- I_CLK  in  1  clock; all logic on rising edge.
- I_SYNC_RST  in  1  synchronous reset, active-high. One clock and synchronous active-high reset are already decided.
- I_START  in  1  one-cycle pulse; latches I_TILE_NUM, clears the accumulator. Honoured only in S_IDLE.
- I_TILE_NUM  in  4  number of tiles to accumulate; 0 is treated as 1.
- I_SA_VLD  in  1  array result-valid (level; stays high until the array is reset).
- I_SA_OUT  in  D_W × [SA_R][SA_C]  array result tile.
- O_SA_CLR  out  1  one-cycle pulse after each capture; drives the array's sync clear.
- O_ROW_VLD  out  1  row beat valid.
- I_ROW_RDY  in  1  downstream ready.
- O_ROW_DATA  out  D_W × [SA_C]  accumulator row O_ROW_IDX.
- O_ROW_IDX  out  $clog2(SA_R)  current row index.
- O_ROW_LAST  out  1  high with the beat for row SA_R-1.
- O_BUSY  out  1  high in any state other than S_IDLE.
- O_DONE  out  1  one-cycle pulse after the last row is accepted.

## Operation
- States: S_IDLE, S_WAIT, S_DRAIN.
- S_IDLE:
  - On I_START: acc ← 0, tile_cnt ← 0, tile_num ← max(I_TILE_NUM,1); go to S_WAIT.
- Edge detect: vld_d registers I_SA_VLD every cycle, in all states. A capture event is I_SA_VLD & !vld_d. A level held high therefore counts once.
- S_WAIT, on a capture event:
  - Per element: acc[r][c] ← sat(acc[r][c] + I_SA_OUT[r][c]). Signed D_W+1-bit sum, clamped to [−2^(D_W−1), 2^(D_W−1)−1], i.e. 0x8000..0x7FFF for D_W=16.
  - tile_cnt ← tile_cnt+1; O_SA_CLR ← 1 for the next cycle.
  - If tile_cnt == tile_num−1, go to S_DRAIN with row ← 0; otherwise stay in S_WAIT.
- S_DRAIN:
  - O_ROW_VLD = 1, O_ROW_DATA = acc[row], O_ROW_IDX = row, O_ROW_LAST = (row == SA_R−1).
  - On O_ROW_VLD & I_ROW_RDY: row ← row+1. On the last row: O_DONE ← 1 next cycle, go to S_IDLE.
- Ignored inputs:
  - I_START outside S_IDLE.
  - Capture events in S_IDLE or S_DRAIN; vld_d still tracks them.
  - I_ROW_RDY outside S_DRAIN.
- The accumulator is retained after S_DRAIN and cleared only by I_START or reset.

## Timing
- Reset (I_SYNC_RST=1 at a clock edge):
  - State S_IDLE; acc, vld_d, tile_cnt and row all 0.
  - All outputs are 0: O_ROW_VLD, O_ROW_DATA, O_ROW_IDX, O_ROW_LAST, O_SA_CLR, O_BUSY, O_DONE.
  - Reset mid-operation aborts immediately. No O_DONE is produced.
- Capture: the event is sampled at edge t. acc is updated at t; O_SA_CLR is high in cycle t..t+1.
- Final tile: the state is S_DRAIN after edge t, so O_ROW_VLD is high in the same cycle as O_SA_CLR.
- Drain: one row per cycle while I_ROW_RDY=1; minimum SA_R cycles.
- Backpressure: while O_ROW_VLD & !I_ROW_RDY, O_ROW_DATA, O_ROW_IDX and O_ROW_LAST hold stable.
- O_DONE is high the cycle after the last handshake, together with O_BUSY=0.
- Back-to-back jobs: I_START is accepted in the same cycle O_DONE is high.

## Test plan
- Single tile, I_TILE_NUM=1, I_SA_OUT[r][c]=r*16+c, I_ROW_RDY=1:
  - O_SA_CLR is one pulse.
  - 16 beats follow with O_ROW_IDX 0..15; row r holds values r*16..r*16+15.
  - O_ROW_LAST is high on row 15; O_DONE pulses once.
- Two tiles, saturation: tile 1 all 0x7000 then tile 2 all 0x2000 → all 0x7FFF. Repeat with 0x9000 + 0xF000 → 0x8000, and 0x2000 + 0xE000 → 0x0000.
- Level hold: I_SA_VLD held high 40 cycles with I_TILE_NUM=2 → exactly one capture, state stays S_WAIT, no drain. The second capture is taken only after I_SA_VLD drops and rises again.
- Backpressure: I_ROW_RDY toggles randomly with 50% duty → 16 beats in order, data stable during stalls, no duplicated or dropped rows.
- I_TILE_NUM=0 → behaves as 1. I_START pulsed while in S_WAIT or S_DRAIN → ignored, tile_cnt unchanged.
- I_SYNC_RST asserted after row 5 is accepted → the next cycle has all outputs 0 and O_BUSY=0. A new I_START then yields a fresh accumulation of the new tiles only, with acc starting from 0.
